// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and latency limits for the ROM port arbiter
package rom_arb_pkg;
  localparam int ROM_LAT_MIN = 1;
  localparam int ROM_LAT_MAX = 3;
  typedef logic req_id_t;
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    err;
  } tag_t;
endpackage

// File: rtl/rom_resp_pipe.sv
// rom_resp_pipe: ROM_LAT-deep tag shift register aligning tags with ROM read data
module rom_resp_pipe
  import rom_arb_pkg::*;
#(
  parameter int ROM_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push_valid,
  input  logic push_id,
  input  logic push_err,
  output logic last_valid,
  output logic last_id,
  output logic last_err
);
  tag_t stages [ROM_LAT];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) stages[i] <= '0;
    end else begin
      stages[0] <= '{valid: push_valid, id: push_id, err: push_err};
      for (int i = 1; i < ROM_LAT; i++) stages[i] <= stages[i-1];
    end
  end
  assign last_valid = stages[ROM_LAT-1].valid;
  assign last_id    = stages[ROM_LAT-1].id;
  assign last_err   = stages[ROM_LAT-1].err;
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: round-robin sharing of the instruction-ROM read port between two requesters
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ROM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_hold,
  input  logic              io_m0_req_valid,
  input  logic [ADDR_W-1:0] io_m0_req_addr,
  output logic              io_m0_req_ready,
  output logic              io_m0_resp_valid,
  output logic [DATA_W-1:0] io_m0_resp_data,
  output logic              io_m0_resp_err,
  input  logic              io_m1_req_valid,
  input  logic [ADDR_W-1:0] io_m1_req_addr,
  output logic              io_m1_req_ready,
  output logic              io_m1_resp_valid,
  output logic [DATA_W-1:0] io_m1_resp_data,
  output logic              io_m1_resp_err,
  output logic              io_rom_ce,
  output logic [ADDR_W-1:0] io_rom_addr,
  input  logic [DATA_W-1:0] io_rom_data
);
  logic              last_grant;
  logic              g0, g1, granted, aligned;
  req_id_t           grant_id;
  logic [ADDR_W-1:0] grant_addr;
  logic              t_valid, t_id, t_err;
  logic [DATA_W-1:0] rdata;
  // on a tie the requester that did not win last time goes first
  assign g0         = !reset && !io_hold && io_m0_req_valid && (!io_m1_req_valid || last_grant);
  assign g1         = !reset && !io_hold && io_m1_req_valid && (!io_m0_req_valid || !last_grant);
  assign granted    = g0 || g1;
  assign grant_id   = g1;
  assign grant_addr = g1 ? io_m1_req_addr : io_m0_req_addr;
  assign aligned    = grant_addr[1:0] == 2'b00;
  assign io_m0_req_ready = g0;
  assign io_m1_req_ready = g1;
  assign io_rom_ce       = granted && aligned;
  assign io_rom_addr     = io_rom_ce ? grant_addr : '0;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant <= 1'b1;
    else if (granted) last_grant <= grant_id;
  end
  rom_resp_pipe #(.ROM_LAT(ROM_LAT)) u_pipe (
    .clock      (clock),
    .reset      (reset),
    .push_valid (granted),
    .push_id    (grant_id),
    .push_err   (!aligned),
    .last_valid (t_valid),
    .last_id    (t_id),
    .last_err   (t_err)
  );
  // misaligned tags never touched the ROM, so their data is forced to zero
  assign rdata            = t_err ? '0 : io_rom_data;
  assign io_m0_resp_valid = t_valid && !t_id;
  assign io_m0_resp_data  = io_m0_resp_valid ? rdata : '0;
  assign io_m0_resp_err   = io_m0_resp_valid && t_err;
  assign io_m1_resp_valid = t_valid && t_id;
  assign io_m1_resp_data  = io_m1_resp_valid ? rdata : '0;
  assign io_m1_resp_err   = io_m1_resp_valid && t_err;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench driving three arbiters (ROM_LAT 1..3) with shared stimulus
module tb_rom_port_arbiter;
  logic clock = 0, reset = 1, io_hold = 0, m0v = 0, m1v = 0;
  logic [31:0] m0a = 0, m1a = 0;
  logic m0_rdy[3], m0_rv[3], m0_re[3], m1_rdy[3], m1_rv[3], m1_re[3], rom_ce[3];
  logic [31:0] m0_rd[3], m1_rd[3], rom_addr[3], rom_data[3];
  int cyc = 0, n_cmp = 0, n_err = 0;
  bit mlast = 1;
  typedef struct { int due; bit id; bit err; logic [31:0] data; } exp_t;
  exp_t sb[3][$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h2401_0011 : {16'hC0DE, a[15:0]};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    logic [31:0] ap [k+1];
    always @(posedge clock) begin
      ap[0] <= rom_addr[k];
      for (int i = 1; i <= k; i++) ap[i] <= ap[i-1];
    end
    assign rom_data[k] = rom_word(ap[k]);
    rom_port_arbiter #(.ROM_LAT(k+1)) dut (
      .clock(clock), .reset(reset), .io_hold(io_hold),
      .io_m0_req_valid(m0v), .io_m0_req_addr(m0a), .io_m0_req_ready(m0_rdy[k]),
      .io_m0_resp_valid(m0_rv[k]), .io_m0_resp_data(m0_rd[k]), .io_m0_resp_err(m0_re[k]),
      .io_m1_req_valid(m1v), .io_m1_req_addr(m1a), .io_m1_req_ready(m1_rdy[k]),
      .io_m1_resp_valid(m1_rv[k]), .io_m1_resp_data(m1_rd[k]), .io_m1_resp_err(m1_re[k]),
      .io_rom_ce(rom_ce[k]), .io_rom_addr(rom_addr[k]), .io_rom_data(rom_data[k])
    );
  end

  // scoreboard: independent grant model pushes expected responses, popped when due
  always @(negedge clock) begin
    logic e0, e1, ece;
    logic [31:0] ga, eaddr;
    logic [67:0] got, want;
    exp_t e;
    if (reset) begin
      mlast = 1;
      for (int k = 0; k < 3; k++) begin
        sb[k].delete();
        n_cmp++;
        if ({m0_rdy[k], m1_rdy[k], rom_ce[k], m0_rv[k], m1_rv[k], m0_re[k], m1_re[k]} !== 7'b0 ||
            rom_addr[k] !== 0 || m0_rd[k] !== 0 || m1_rd[k] !== 0) begin
          n_err++;
          $display("FAIL reset_outputs lat%0d: rdy=%b%b ce=%b rv=%b%b addr=%h", k+1,
                   m0_rdy[k], m1_rdy[k], rom_ce[k], m0_rv[k], m1_rv[k], rom_addr[k]);
        end
      end
    end else begin
      e0 = !io_hold && m0v && (!m1v || mlast);
      e1 = !io_hold && m1v && (!m0v || !mlast);
      ga = e1 ? m1a : m0a;
      ece = (e0 || e1) && ga[1:0] == 2'b00;
      eaddr = ece ? ga : 32'h0;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if ({m0_rdy[k], m1_rdy[k], rom_ce[k]} !== {e0, e1, ece} || rom_addr[k] !== eaddr) begin
          n_err++;
          $display("FAIL grant lat%0d cyc%0d: rdy=%b%b ce=%b addr=%h expected rdy=%b%b ce=%b addr=%h",
                   k+1, cyc, m0_rdy[k], m1_rdy[k], rom_ce[k], rom_addr[k], e0, e1, ece, eaddr);
        end
        if (e0 || e1) sb[k].push_back('{cyc + k + 1, e1, !ece, ece ? rom_word(ga) : 32'h0});
      end
      if (e0 || e1) mlast = e1;
      for (int k = 0; k < 3; k++) begin
        got = {m0_rv[k], m0_re[k], m0_rd[k], m1_rv[k], m1_re[k], m1_rd[k]};
        want = '0;
        if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
          e = sb[k].pop_front();
          want = e.id ? {34'b0, 1'b1, e.err, e.data} : {1'b1, e.err, e.data, 34'b0};
        end
        n_cmp++;
        if (got !== want) begin
          n_err++;
          $display("FAIL response lat%0d cyc%0d: got %h expected %h", k+1, cyc, got, want);
        end
      end
    end
  end

  task automatic step(input bit h, input bit v0, input logic [31:0] a0, input bit v1, input logic [31:0] a1);
    @(posedge clock);
    #1;
    io_hold = h; m0v = v0; m0a = a0; m1v = v1; m1a = a1;
  endtask

  task automatic do_reset;
    @(posedge clock);
    #1;
    reset = 1; io_hold = 0; m0v = 0; m1v = 0; m0a = 0; m1a = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    step(0, 1, 32'h4, 1, 32'h8);
    @(negedge clock);
    n_cmp++;
    if (m0_rdy[0] !== 0 || m1_rdy[0] !== 0 || rom_ce[0] !== 0) begin
      n_err++;
      $display("FAIL reset_ready: rdy=%b%b ce=%b expected 000", m0_rdy[0], m1_rdy[0], rom_ce[0]);
    end
    step(0, 0, 0, 0, 0);
    reset = 0;
  endtask

  task automatic test_single;
    step(0, 1, 32'h4, 0, 0);
    @(negedge clock);
    n_cmp++;
    if (m0_rdy[0] !== 1 || rom_ce[0] !== 1 || rom_addr[0] !== 32'h4) begin
      n_err++;
      $display("FAIL single_grant: rdy=%b ce=%b addr=%h expected 1 1 00000004", m0_rdy[0], rom_ce[0], rom_addr[0]);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    n_cmp++;
    if (m0_rv[0] !== 1 || m0_rd[0] !== 32'h2401_0011 || m1_rv[0] !== 0 || m1_rd[0] !== 0 || m1_re[0] !== 0) begin
      n_err++;
      $display("FAIL single_resp: rv=%b data=%h m1rv=%b expected 1 24010011 0", m0_rv[0], m0_rd[0], m1_rv[0]);
    end
  endtask

  task automatic test_tie;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h0, 1, 32'h100);
      @(negedge clock);
      n_cmp++;
      if (m0_rdy[0] !== (i % 2 == 0) || m1_rdy[0] !== (i % 2 == 1)) begin
        n_err++;
        $display("FAIL tie_alternate step%0d: rdy=%b%b expected m%0d", i, m0_rdy[0], m1_rdy[0], i % 2);
      end
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_misaligned;
    step(0, 0, 0, 1, 32'h102);
    @(negedge clock);
    n_cmp++;
    if (m1_rdy[0] !== 1 || rom_ce[0] !== 0 || rom_addr[0] !== 0) begin
      n_err++;
      $display("FAIL misaligned_grant: rdy=%b ce=%b addr=%h expected 1 0 0", m1_rdy[0], rom_ce[0], rom_addr[0]);
    end
    step(0, 0, 0, 0, 0);
    @(negedge clock);
    n_cmp++;
    if (m1_rv[0] !== 1 || m1_re[0] !== 1 || m1_rd[0] !== 0) begin
      n_err++;
      $display("FAIL misaligned_resp: rv=%b err=%b data=%h expected 1 1 0", m1_rv[0], m1_re[0], m1_rd[0]);
    end
  endtask

  task automatic test_hold;
    step(0, 1, 32'h8, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 32'hC, 0, 0);
      @(negedge clock);
      n_cmp++;
      if (m0_rdy[0] !== 0 || rom_ce[0] !== 0 || m0_rv[i] !== 1 || m0_rd[i] !== rom_word(32'h8)) begin
        n_err++;
        $display("FAIL hold step%0d: rdy=%b ce=%b rv_lat%0d=%b data=%h expected 0 0 1 %h",
                 i, m0_rdy[0], rom_ce[0], i+1, m0_rv[i], m0_rd[i], rom_word(32'h8));
      end
    end
    step(0, 1, 32'hC, 0, 0);
    @(negedge clock);
    n_cmp++;
    if (m0_rdy[0] !== 1) begin
      n_err++;
      $display("FAIL hold_release: rdy=%b expected 1", m0_rdy[0]);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_drop_valid;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 1, 32'h200);
      @(negedge clock);
      n_cmp++;
      if (m1_rdy[0] !== 0) begin
        n_err++;
        $display("FAIL drop_valid step%0d: rdy=%b expected 0", i, m1_rdy[0]);
      end
    end
    repeat (4) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_stream;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(0, 1, 32'(i * 4), 0, 0);
      else step(0, 0, 0, 0, 0);
      @(negedge clock);
      if (i < 4) begin
        n_cmp++;
        if (m0_rdy[0] !== 1) begin
          n_err++;
          $display("FAIL stream_accept step%0d: rdy=%b expected 1", i, m0_rdy[0]);
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if (m0_rv[1] !== 1 || m0_rd[1] !== rom_word(32'((i - 2) * 4))) begin
          n_err++;
          $display("FAIL stream_resp step%0d: rv=%b data=%h expected 1 %h", i, m0_rv[1], m0_rd[1], rom_word(32'((i - 2) * 4)));
        end
      end
    end
    repeat (3) step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midflight;
    step(0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 1, 32'h24);
    do_reset;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (m0_rv[k] !== 0 || m1_rv[k] !== 0) begin
          n_err++;
          $display("FAIL stale_resp lat%0d step%0d: rv=%b%b expected 00", k+1, i, m0_rv[k], m1_rv[k]);
        end
      end
      step(0, 0, 0, 0, 0);
    end
    step(0, 1, 32'h0, 1, 32'h100);
    @(negedge clock);
    n_cmp++;
    if (m0_rdy[0] !== 1 || m1_rdy[0] !== 0) begin
      n_err++;
      $display("FAIL reset_tie: rdy=%b%b expected 10", m0_rdy[0], m1_rdy[0]);
    end
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_misaligned;
    test_hold;
    test_drop_valid;
    test_stream;
    test_reset_midflight;
    repeat (6) step(0, 0, 0, 0, 0);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (sb[k].size() != 0) begin
        n_err++;
        $display("FAIL drain lat%0d: %0d responses outstanding, expected 0", k+1, sb[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1);
  end
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single instruction-ROM read port between two requesters.
  - Requester 0: CPU instruction fetch.
  - Requester 1: debug/loader readback.
- Grants at most one request per cycle, using round-robin priority on ties.
- Drives the ROM ce/addr pins and routes each returned word back to the requester that issued it, a fixed latency later.
- Sits between the CPU fetch port and the ROM in the SoC top.

Parameters:
- ADDR_W, 32, width of the ROM byte address.
- DATA_W, 32, width of the ROM word.
- ROM_LAT, 1, clock edges from a sampled ce/addr to valid io_rom_data; legal range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_hold  in  1  when 1, no new grants are issued; in-flight reads still complete.
- io_m0_req_valid  in  1  requester 0 has a read pending.
- io_m0_req_addr  in  ADDR_W  requester 0 byte address.
- io_m0_req_ready  out  1  requester 0 request accepted this cycle.
- io_m0_resp_valid  out  1  requester 0 response this cycle.
- io_m0_resp_data  out  DATA_W  requester 0 read data.
- io_m0_resp_err  out  1  requester 0 response is a misalignment error.
- io_m1_req_valid, io_m1_req_addr, io_m1_req_ready, io_m1_resp_valid, io_m1_resp_data, io_m1_resp_err: same directions, widths and meanings as the m0 ports, for requester 1.
- io_rom_ce  out  1  ROM chip enable.
- io_rom_addr  out  ADDR_W  ROM address.
- io_rom_data  in  DATA_W  ROM read data.

Behaviour:
- Reset (async, active-high):
  - All outputs read 0 while reset is high, including the ready signals, which are gated by reset.
  - The in-flight tag pipeline is cleared; reads in flight at reset produce no response.
  - last_grant is set to 1, so m0 wins the first tie.
- Arbitration (combinational within the cycle):
  - No grant is issued if io_hold=1 or neither requester is valid.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester other than last_grant is granted.
  - last_grant updates on every accepted request.
- Grant outputs:
  - io_mX_req_ready=1 only for the granted requester.
  - A transfer completes when valid and ready are both 1.
  - A requester must hold valid and addr stable until it sees ready.
- ROM drive:
  - For an aligned grant (addr[1:0]==0): io_rom_ce=1 and io_rom_addr=the granted address.
  - Otherwise io_rom_ce=0 and io_rom_addr=0.
- Misaligned grant (addr[1:0]!=0):
  - The request is still accepted (ready=1) but the ROM is not accessed.
  - The tag records err=1.
- Tag pipeline:
  - ROM_LAT stages of {valid, id, err}.
  - A tag is pushed on every accepted request and shifts each clock.
- Response:
  - Issued when the tag at the last stage is valid, i.e. exactly ROM_LAT cycles after acceptance.
  - io_m[id]_resp_valid=1.
  - io_m[id]_resp_data = io_rom_data when err=0, else 0.
  - io_m[id]_resp_err = err.
  - The other requester's resp outputs are all 0.
- No response backpressure: requesters must accept a response in the cycle it is presented.
- Throughput: one accepted request per cycle sustained, so back-to-back grants pipeline fully.
- Responses return in acceptance order.
- Boundary conditions:
  - io_hold asserted while reads are in flight: no new grants; pending responses still appear on schedule.
  - Both requesters valid continuously: grants strictly alternate 0,1,0,1…
  - A requester that drops valid without ever seeing ready: legal; no side effects.
  - Reset mid-burst: no responses from pre-reset requests ever appear after reset deasserts.

Decomposition:
- Shared package rom_arb_pkg:
  - requester-id type (1 bit);
  - tag struct {valid, id, err};
  - ROM_LAT_MIN=1 and ROM_LAT_MAX=3 constants.
- Sub-module rom_resp_pipe: ROM_LAT-deep tag shift register with async reset, push input and last-stage output.
- The arbiter instantiates rom_resp_pipe and holds the arbitration logic and the last_grant flop.

Test Plan:
- Single requester, ROM_LAT=1: m0 reads 0x0000_0004 with ROM word=0x2401_0011 → ready in the same cycle; rom_ce=1, rom_addr=0x4; one cycle later m0_resp_valid=1, data=0x2401_0011, m1 resp all 0.
- Tie after reset: both valid, m0 addr=0x0, m1 addr=0x100 held for 4 cycles → grants 0,1,0,1; responses alternate, each carrying the word at its own address.
- Misaligned request: m1 addr=0x0000_0102 → ready=1 and rom_ce=0; after ROM_LAT cycles m1_resp_valid=1, err=1, data=0.
- Hold: io_hold=1 for 3 cycles with m0 valid → no ready and rom_ce=0; a response from the access accepted the cycle before hold still appears on schedule; granting resumes the cycle after hold drops.
- Reset mid-flight, ROM_LAT=3: accept two reads, then pulse reset for 1 cycle → no resp_valid for 5 cycles; the next tie is won by m0.
- Streaming, ROM_LAT=2: m0 issues addresses 0x0, 0x4, 0x8, 0xC in 4 consecutive cycles → 4 consecutive responses, in order, starting 2 cycles after the first accept.
